pkt_gen_pkt_builder: RTL
========================

PKT_GEN_PKT_BUILDER -- requirements
Module: pkt_gen_pkt_builder

Interface
REQ-001 SHALL have parameter FLOW_CNT, default 16, number of flows.
REQ-002 SHALL have parameter FLOW_CNT_WIDTH, default (FLOW_CNT==1) ? 1 : clog2(FLOW_CNT), flow index width; internal, not overridden.
REQ-003 SHALL have port clk_i  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port task_flow_num_i  input  FLOW_CNT_WIDTH  flow number of the offered task.
REQ-006 SHALL have port task_pkt_size_i  input  16  requested packet size in bytes.
REQ-007 SHALL have port task_valid_i  input  1  task offered.
REQ-008 SHALL have port task_ready_o  output  1  builder accepts task this cycle.
REQ-009 SHALL have port seq_clr_i  input  1  synchronous clear of all per-flow sequence counters.
REQ-010 SHALL have ports pkt_data_o  output  64  stream data, first byte in bits [63:56].
REQ-011 SHALL have ports pkt_startofpacket_o / pkt_endofpacket_o  output  1 each  packet delimiters.
REQ-012 SHALL have port pkt_empty_o  output  3  count of unused bytes in the eop word.
REQ-013 SHALL have ports pkt_valid_o  output  1 and pkt_ready_i  input  1  stream handshake; a transfer occurs when both are high.

Function
REQ-014 SHALL implement FSM IDLE -> HDR -> BODY -> IDLE.
- IDLE: task_ready_o=1; on task_valid_i go to HDR and latch flow number and effective size.
- HDR: sop word.
- BODY: remaining words.
REQ-015 SHALL set task_ready_o high only in IDLE; a task is accepted on the cycle when task_valid_i and task_ready_o are both high.
REQ-016 SHALL compute effective size = clamp(task_pkt_size_i, 60, 9600).
REQ-017 SHALL compute word count W = ceil(size/8), counted by a 11-bit word counter.
REQ-018 SHALL assert pkt_valid_o with the sop word on the cycle after task acceptance (latency 1).
REQ-019 SHALL form word 0 as {16'(flow_num), size[15:0], seq[flow][31:0]}, with sop=1.
REQ-020 SHALL form word k (1..W-1) as {16'hA5A5, k[15:0], 16'hA5A5, k[15:0]}.
REQ-021 SHALL assert eop on word W-1 with empty = (8 - size%8) % 8, and drive empty=0 on all other words.
REQ-022 SHALL assert sop and eop on the same word when W==1 (unreachable with the clamp; logic SHALL still handle it).
REQ-023 SHALL hold data, sop, eop and empty stable while pkt_valid_o=1 and pkt_ready_i=0, and advance only on a transfer.
REQ-024 SHALL keep pkt_valid_o high continuously from sop to eop (no gaps within a packet).
REQ-025 SHALL return to IDLE on the eop transfer, so the next sop comes at the earliest 2 cycles after the previous eop (one-cycle bubble).
REQ-026 SHALL hold seq[flow] as a 32-bit register array, incremented on the sop transfer; 32'hFFFF_FFFF wraps to 0.
REQ-027 SHALL let seq_clr_i zero all counters in the next cycle; when clear coincides with an increment, clear wins.
REQ-028 SHALL sample the header seq value at the HDR word output; a clear issued while the sop word is stalled SHALL NOT alter that pending word.

Reset
REQ-029 SHALL on rst_i force: state IDLE, task_ready_o=0 while reset is asserted, pkt_valid_o=0, sop=0, eop=0, empty=0, pkt_data_o=0, all seq counters 0, word counter 0.
REQ-030 SHALL abandon any packet in flight on reset mid-packet, with no eop emitted; after reset release the first packet starts with sop.

Structure
REQ-031 SHALL place MIN_PKT_SIZE=60, MAX_PKT_SIZE=9600, PAYLOAD_PATTERN=16'hA5A5 and the builder state enum in shared package pkt_gen_pkg.
REQ-032 SHALL be a single module with no sub-modules; the seq counters are a flop array, since FLOW_CNT is small.

Verification
REQ-033 SHALL cover: task flow=3, size=64, ready always 1 -> 8 words; sop on word 0 = {16'h0003, 16'h0040, 32'h0}; eop on word 7; empty=0.
REQ-034 SHALL cover: size=65 -> 9 words, empty=7; size=30 -> clamped to 60 -> 8 words, header size 16'h003C, empty=4.
REQ-035 SHALL cover: size=10000 -> clamped to 9600 -> 1200 words, empty=0, last word k field = 16'd1199.
REQ-036 SHALL cover: random pkt_ready_i deassertion (50%) -> data/sop/eop/empty unchanged during stalls; task_ready_o=0 until after eop.
REQ-037 SHALL cover: three packets on flow 5, then seq_clr_i pulse, then one more -> header seq values 0, 1, 2, then 0; flow 2 counter unaffected by flow 5 traffic.
REQ-038 SHALL cover: rst_i asserted at word 4 of a 60-byte packet -> pkt_valid_o=0 immediately; after release, the next task yields sop with seq=0.

Source files
------------

// File: rtl/pkt_gen_pkg.sv
// Shared constants, builder state encoding and small arithmetic helpers
// used by the packet generator blocks.
package pkt_gen_pkg;

   localparam logic [15:0] MIN_PKT_SIZE    = 16'd60;
   localparam logic [15:0] MAX_PKT_SIZE    = 16'd9600;
   localparam logic [15:0] PAYLOAD_PATTERN = 16'hA5A5;
   localparam int unsigned WCNT_W          = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_BODY = 2'd2
   } bld_state_e;

   function automatic logic [15:0] clamp_size(input logic [15:0] sz);
      if (sz < MIN_PKT_SIZE)      return MIN_PKT_SIZE;
      else if (sz > MAX_PKT_SIZE) return MAX_PKT_SIZE;
      else                        return sz;
   endfunction

   // Only valid for clamped sizes, where sz+7 cannot overflow 16 bits.
   function automatic logic [WCNT_W-1:0] word_count(input logic [15:0] sz);
      return WCNT_W'((sz + 16'd7) >> 3);
   endfunction

   function automatic logic [2:0] empty_bytes(input logic [2:0] sz_lo);
      return 3'd0 - sz_lo;
   endfunction

   function automatic logic [63:0] body_word(input logic [WCNT_W-1:0] k);
      logic [15:0] k16;
      k16 = 16'(k);
      return {PAYLOAD_PATTERN, k16, PAYLOAD_PATTERN, k16};
   endfunction

endpackage

// File: rtl/pkt_gen_pkt_builder.sv
// Turns (flow, size) tasks into 64-bit streaming packets: a header word
// carrying flow/size/per-flow sequence number followed by patterned payload.
module pkt_gen_pkt_builder
   import pkt_gen_pkg::*;
#(
   parameter int FLOW_CNT       = 16,
   parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_i,
   input  logic [15:0]               task_pkt_size_i,
   input  logic                      task_valid_i,
   output logic                      task_ready_o,
   input  logic                      seq_clr_i,
   output logic [63:0]               pkt_data_o,
   output logic                      pkt_startofpacket_o,
   output logic                      pkt_endofpacket_o,
   output logic [2:0]                pkt_empty_o,
   output logic                      pkt_valid_o,
   input  logic                      pkt_ready_i
);

   bld_state_e                state_q;
   logic                      ready_q;
   logic [FLOW_CNT_WIDTH-1:0] flow_q;
   logic [2:0]                size_lo_q;
   logic [WCNT_W-1:0]         wtot_q;
   logic [WCNT_W-1:0]         wcnt_q;
   logic                      valid_q;
   logic                      sop_q;
   logic                      eop_q;
   logic [2:0]                empty_q;
   logic [63:0]               data_q;
   logic [31:0]               seq_q [FLOW_CNT];

   logic                      task_acc;
   logic                      xfer;
   logic [15:0]               eff_size_d;
   logic [WCNT_W-1:0]         wtot_d;
   logic [WCNT_W-1:0]         wcnt_d;
   logic                      last_d;
   logic [63:0]               hdr_word_d;

   always_comb begin
      task_acc   = task_valid_i & ready_q;
      xfer       = valid_q & pkt_ready_i;
      eff_size_d = clamp_size(task_pkt_size_i);
      wtot_d     = word_count(eff_size_d);
      wcnt_d     = wcnt_q + WCNT_W'(1);
      last_d     = (wcnt_d == wtot_q - WCNT_W'(1));
      hdr_word_d = {16'(task_flow_num_i), eff_size_d, seq_q[task_flow_num_i]};
   end

   // The header is built from the counter at acceptance and held in data_q,
   // so a clear while the sop word is stalled leaves that word untouched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b0;
         flow_q    <= '0;
         size_lo_q <= '0;
         wtot_q    <= '0;
         wcnt_q    <= '0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         empty_q   <= '0;
         data_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ready_q <= 1'b1;
               if (task_acc) begin
                  state_q   <= ST_HDR;
                  ready_q   <= 1'b0;
                  flow_q    <= task_flow_num_i;
                  size_lo_q <= eff_size_d[2:0];
                  wtot_q    <= wtot_d;
                  wcnt_q    <= '0;
                  valid_q   <= 1'b1;
                  sop_q     <= 1'b1;
                  eop_q     <= (wtot_d == WCNT_W'(1));
                  empty_q   <= (wtot_d == WCNT_W'(1)) ? empty_bytes(eff_size_d[2:0]) : 3'd0;
                  data_q    <= hdr_word_d;
               end
            end
            ST_HDR, ST_BODY: begin
               if (xfer) begin
                  if (eop_q) begin
                     state_q <= ST_IDLE;
                     ready_q <= 1'b1;
                     wcnt_q  <= '0;
                     valid_q <= 1'b0;
                     sop_q   <= 1'b0;
                     eop_q   <= 1'b0;
                     empty_q <= '0;
                  end else begin
                     state_q <= ST_BODY;
                     wcnt_q  <= wcnt_d;
                     sop_q   <= 1'b0;
                     eop_q   <= last_d;
                     empty_q <= last_d ? empty_bytes(size_lo_q) : 3'd0;
                     data_q  <= body_word(wcnt_d);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Clear has priority over the sop-transfer increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FLOW_CNT; i++) seq_q[i] <= '0;
      end else if (seq_clr_i) begin
         for (int i = 0; i < FLOW_CNT; i++) seq_q[i] <= '0;
      end else if ((state_q == ST_HDR) && xfer) begin
         seq_q[flow_q] <= seq_q[flow_q] + 32'd1;
      end
   end

   assign task_ready_o        = ready_q;
   assign pkt_valid_o         = valid_q;
   assign pkt_startofpacket_o = sop_q;
   assign pkt_endofpacket_o   = eop_q;
   assign pkt_empty_o         = empty_q;
   assign pkt_data_o          = data_q;

endmodule
